ysyx_24100006_hazard_sb: RTL and testbench

Parametrised scoreboard-based hazard and forwarding unit for the ysyx_24100006 in-order pipeline. It tracks every in-flight register write in per-stage slots (EX, MEM, WB by default). For each source operand in ID it computes a forward-select code, and it raises `stall_id` only when the youngest matching producer has no data yet: a load waiting for memory, or any match when forwarding is disabled. Load readiness is held as per-slot state, so correctness does not depend on edge-detecting downstream ready signals.

---
 rtl/ysyx_24100006_hazard_sb.sv | 146 ++++++++++++++
 tb/tb_ysyx_24100006_hazard_sb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_hazard_sb.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_24100006_hazard_sb
// Purpose  : Scoreboard hazard/forwarding unit that tracks in-flight writes per stage.
// Revision : 1.0
// =============================================================================
module ysyx_24100006_hazard_sb #(
  parameter int AW         = 4,
  parameter int NSRC       = 2,
  parameter int NSTAGE     = 3,
  parameter int LOAD_STAGE = 1,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32,
  localparam int SW        = $clog2(NSTAGE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_fire,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_rs_ren,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_wen,
  input  logic                 id_is_load,
  input  logic [NSTAGE-1:0]    st_fire,
  input  logic [NSTAGE-1:0]    flush_mask,
  input  logic                 mem_rvalid,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 stall_id,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic [NSTAGE-1:0]         v;
  logic [NSTAGE-1:0]         w;
  logic [NSTAGE-1:0]         ld;
  logic [NSTAGE-1:0]         rdy;
  logic [NSTAGE-1:0]         eff_rdy;
  logic [NSTAGE-1:0][AW-1:0] rd;
  logic [NSRC-1:0]           blocked;

  generate
    for (genvar i = 0; i < NSTAGE; i++) begin : g_slot
      logic          s_v;
      logic          s_w;
      logic          s_ld;
      logic          s_rdy;
      logic [AW-1:0] s_rd;

      assign v[i]   = s_v;
      assign w[i]   = s_w;
      assign ld[i]  = s_ld;
      assign rdy[i] = s_rdy;
      assign rd[i]  = s_rd;

      // Load data arriving this cycle makes the LOAD_STAGE occupant usable immediately.
      assign eff_rdy[i] = s_rdy | ~s_ld | ((i == LOAD_STAGE) & mem_rvalid);

      if (i == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            s_v   <= 1'b0;
            s_w   <= 1'b0;
            s_ld  <= 1'b0;
            s_rdy <= 1'b0;
            s_rd  <= '0;
          end else if (flush_mask[0]) begin
            s_v <= 1'b0;
          end else if (id_fire) begin
            s_v   <= 1'b1;
            s_w   <= id_wen & (id_rd != '0);
            s_ld  <= id_is_load;
            s_rdy <= ~id_is_load;
            s_rd  <= id_rd;
          end else begin
            if (st_fire[0]) s_v <= 1'b0;
            s_rdy <= eff_rdy[0];
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (reset) begin
            s_v   <= 1'b0;
            s_w   <= 1'b0;
            s_ld  <= 1'b0;
            s_rdy <= 1'b0;
            s_rd  <= '0;
          end else if (flush_mask[i]) begin
            s_v <= 1'b0;
          end else if (st_fire[i-1]) begin
            // Readiness travels with the entry, including data arriving on this edge.
            s_v   <= v[i-1];
            s_w   <= w[i-1];
            s_ld  <= ld[i-1];
            s_rdy <= eff_rdy[i-1];
            s_rd  <= rd[i-1];
          end else begin
            if (st_fire[i]) s_v <= 1'b0;
            s_rdy <= eff_rdy[i];
          end
        end
      end
    end
  endgenerate

  generate
    for (genvar k = 0; k < NSRC; k++) begin : g_src
      logic [AW-1:0] rs;
      logic          hit;
      logic          blk;
      logic [SW-1:0] sel;

      assign rs = id_rs[k*AW +: AW];

      // Scan oldest to youngest so the lowest matching slot has the final say.
      always_comb begin
        hit = 1'b0;
        blk = 1'b0;
        sel = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
          if (id_rs_ren[k] && (rs != '0) && v[i] && w[i] && (rd[i] == rs)) begin
            hit = 1'b1;
            blk = ~eff_rdy[i];
            sel = SW'(i + 1);
          end
        end
        if (FWD_EN == 0) blk = hit;
        if (!id_valid || blk) sel = '0;
      end

      assign blocked[k]           = blk;
      assign fwd_sel[k*SW +: SW]  = sel;
    end
  endgenerate

  assign stall_id = id_valid & (|blocked);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_id && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_hazard_sb.sv
`default_nettype none
// =============================================================================
// Module   : tb_ysyx_24100006_hazard_sb
// Purpose  : Scoreboard-driven bench for the hazard/forwarding unit.
// Revision : 1.0
// =============================================================================
module tb_ysyx_24100006_hazard_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_fire, id_wen, id_is_load, mem_rvalid;
  logic [7:0] id_rs;
  logic [1:0] id_rs_ren;
  logic [3:0] id_rd;
  logic [2:0] st_fire, flush_mask;
  logic [3:0] fwd_sel, nf_sel;
  logic       stall_id, nf_stall;
  logic [31:0] stall_cnt;
  logic [3:0] nf_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_24100006_hazard_sb u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_fire(id_fire),
    .id_rs(id_rs), .id_rs_ren(id_rs_ren), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .st_fire(st_fire), .flush_mask(flush_mask),
    .mem_rvalid(mem_rvalid), .fwd_sel(fwd_sel), .stall_id(stall_id),
    .stall_cnt(stall_cnt)
  );

  ysyx_24100006_hazard_sb #(.FWD_EN(0), .CNT_W(4)) u_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_fire(id_fire),
    .id_rs(id_rs), .id_rs_ren(id_rs_ren), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .st_fire(st_fire), .flush_mask(flush_mask),
    .mem_rvalid(mem_rvalid), .fwd_sel(nf_sel), .stall_id(nf_stall),
    .stall_cnt(nf_cnt)
  );

  typedef struct {
    logic       vld, fire;
    logic [3:0] rs0, rs1;
    logic [1:0] ren;
    logic [3:0] rd;
    logic       wen, ld;
    logic [2:0] stf, fl;
    logic       mrv;
    logic       xs;
    logic [1:0] x0, x1;
  } step_t;

  step_t sb[$];

  function automatic step_t mk(input logic vld, input logic fire,
                               input logic [3:0] rs0, input logic [3:0] rs1,
                               input logic [1:0] ren, input logic [3:0] rd,
                               input logic wen, input logic ld,
                               input logic [2:0] stf, input logic [2:0] fl,
                               input logic mrv, input logic xs,
                               input logic [1:0] x0, input logic [1:0] x1);
    step_t s;
    s.vld = vld; s.fire = fire; s.rs0 = rs0; s.rs1 = rs1; s.ren = ren;
    s.rd = rd; s.wen = wen; s.ld = ld; s.stf = stf; s.fl = fl; s.mrv = mrv;
    s.xs = xs; s.x0 = x0; s.x1 = x1;
    return s;
  endfunction

  task automatic apply(input step_t s);
    id_valid   = s.vld;
    id_fire    = s.fire;
    id_rs      = {s.rs1, s.rs0};
    id_rs_ren  = s.ren;
    id_rd      = s.rd;
    id_wen     = s.wen;
    id_is_load = s.ld;
    st_fire    = s.stf;
    flush_mask = s.fl;
    mem_rvalid = s.mrv;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Firing an instruction out of a stalled ID is a protocol violation.
  always @(negedge clk) begin
    if (reset === 1'b0 && id_fire === 1'b1 && stall_id === 1'b1) begin
      fails++;
      $display("FAIL protocol: id_fire=1 while stall_id=1 at %0t", $time);
    end
  end

  task automatic test_reset();
    do_reset();
    apply(mk(1, 0, 5, 3, 2'b11, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    #2;
    tests++;
    if (stall_id !== 1'b0 || fwd_sel !== 4'd0 || stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: got stall=%b sel=%h cnt=%0d, expected 0/0/0", stall_id, fwd_sel, stall_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_alu_b2b();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 5, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b001, 3'b000, 0, 0, 1, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b010, 3'b000, 0, 0, 2, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b100, 3'b000, 0, 0, 3, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (stall_id !== e.xs || fwd_sel[1:0] !== e.x0 || fwd_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL alu_b2b step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, stall_id, fwd_sel[1:0], fwd_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_load_use();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 3, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b001, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 2));
    s.push_back(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b010, 3'b000, 0, 0, 0, 2));
    s.push_back(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 3));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (stall_id !== e.xs || fwd_sel[1:0] !== e.x0 || fwd_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL load_use step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, stall_id, fwd_sel[1:0], fwd_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    tests++;
    if (stall_cnt !== 32'd3) begin
      fails++;
      $display("FAIL load_use_cnt: got %0d, expected 3", stall_cnt);
    end
    idle();
  endtask

  task automatic test_youngest();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 7, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 2'b00, 7, 1, 1, 3'b010, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 7, 0, 2'b01, 0, 0, 0, 3'b001, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 7, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 7, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 1, 0, 2, 0));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (stall_id !== e.xs || fwd_sel[1:0] !== e.x0 || fwd_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL youngest step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, stall_id, fwd_sel[1:0], fwd_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_x0_disabled();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 0, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 2'b01, 9, 1, 0, 3'b001, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 9, 9, 2'b10, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 1));
    s.push_back(mk(0, 0, 9, 9, 2'b11, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (stall_id !== e.xs || fwd_sel[1:0] !== e.x0 || fwd_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL x0_disabled step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, stall_id, fwd_sel[1:0], fwd_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_flush();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 4, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 4, 0, 2'b01, 0, 0, 0, 3'b000, 3'b001, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 4, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 2'b00, 4, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 3'b010, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 4, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (stall_id !== e.xs || fwd_sel[1:0] !== e.x0 || fwd_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL flush step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, stall_id, fwd_sel[1:0], fwd_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_load_handoff();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 6, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 6, 0, 2'b01, 0, 0, 0, 3'b010, 3'b000, 1, 0, 2, 0));
    s.push_back(mk(1, 0, 6, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 3, 0));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (stall_id !== e.xs || fwd_sel[1:0] !== e.x0 || fwd_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL load_handoff step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, stall_id, fwd_sel[1:0], fwd_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    apply(mk(1, 1, 0, 0, 2'b00, 3, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
    tick();
    apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0));
    tick();
    apply(mk(1, 0, 0, 3, 2'b10, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    #2;
    tests++;
    if (stall_id !== 1'b1) begin
      fails++;
      $display("FAIL midop_pre: got stall=%b, expected 1", stall_id);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    tests++;
    if (stall_id !== 1'b0 || fwd_sel !== 4'd0 || stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL midop_post: got stall=%b sel=%h cnt=%0d, expected 0/0/0", stall_id, fwd_sel, stall_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_no_fwd();
    step_t s[$];
    step_t e;
    do_reset();
    s.push_back(mk(1, 1, 0, 0, 2'b00, 5, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b001, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b010, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b100, 3'b000, 0, 1, 0, 0));
    s.push_back(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (s[j]) begin
      apply(s[j]); sb.push_back(s[j]); #2;
      e = sb.pop_front(); tests++;
      if (nf_stall !== e.xs || nf_sel[1:0] !== e.x0 || nf_sel[3:2] !== e.x1) begin
        fails++;
        $display("FAIL no_fwd step %0d: got stall=%b sel=%0d/%0d, expected stall=%b sel=%0d/%0d",
                 j, nf_stall, nf_sel[1:0], nf_sel[3:2], e.xs, e.x0, e.x1);
      end
      tick();
    end
    tests++;
    if (nf_cnt !== 4'd3) begin
      fails++;
      $display("FAIL no_fwd_cnt: got %0d, expected 3", nf_cnt);
    end

    // Reset while stalled, then saturate the narrow counter.
    apply(mk(1, 1, 0, 0, 2'b00, 5, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    tick();
    apply(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    tests++;
    if (nf_stall !== 1'b0 || nf_cnt !== 4'd0) begin
      fails++;
      $display("FAIL no_fwd_reset: got stall=%b cnt=%0d, expected 0/0", nf_stall, nf_cnt);
    end
    tick();
    apply(mk(1, 1, 0, 0, 2'b00, 5, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    tick();
    apply(mk(1, 0, 5, 0, 2'b01, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    repeat (20) tick();
    tests++;
    if (nf_stall !== 1'b1 || nf_cnt !== 4'd15) begin
      fails++;
      $display("FAIL no_fwd_sat: got stall=%b cnt=%0d, expected 1/15", nf_stall, nf_cnt);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_alu_b2b();
    test_load_use();
    test_youngest();
    test_x0_disabled();
    test_flush();
    test_load_handoff();
    test_reset_midop();
    test_no_fwd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
